cpu_sequencer: RTL and testbench



---
 rtl/cpu_sequencer_pkg.sv | 30 +++
 rtl/cpu_sequencer.sv | 144 ++++++++++++++
 tb/tb_cpu_sequencer.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_sequencer_pkg.sv
// Shared widths, instruction field slices and FSM state encoding for the
// control sequencer that sits in front of the ALU.
package cpu_sequencer_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int BUS_WIDTH    = 4;
  localparam int OPCODE_WIDTH = 6;
  localparam int PC_WIDTH     = 8;
  localparam int INSTR_WIDTH  = OPCODE_WIDTH + 2 * BUS_WIDTH;

  // Instruction word layout: {opcode, addr1, addr2}
  localparam int OPCODE_MSB = INSTR_WIDTH - 1;
  localparam int OPCODE_LSB = 2 * BUS_WIDTH;
  localparam int ADDR1_MSB  = 2 * BUS_WIDTH - 1;
  localparam int ADDR1_LSB  = BUS_WIDTH;
  localparam int ADDR2_MSB  = BUS_WIDTH - 1;
  localparam int ADDR2_LSB  = 0;

  localparam logic [OPCODE_WIDTH-1:0] FINISH_OPCODE = '1;

  typedef enum logic [2:0] {
    SIDLE,
    SFETCH,
    SREAD,
    SCALC,
    SWRITE,
    SHALT
  } state_t;

endpackage

// File: rtl/cpu_sequencer.sv
// Fetch / read / calc / write sequencer driving the ALU and register file.
// Strobes are registered and set on the edge that enters their state.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    start,
  output logic                    imem_req,
  output logic [PC_WIDTH-1:0]     imem_addr,
  input  logic                    imem_ack,
  input  logic [INSTR_WIDTH-1:0]  imem_data,
  output logic [BUS_WIDTH-1:0]    rf_raddr1,
  output logic [BUS_WIDTH-1:0]    rf_raddr2,
  input  logic [DATA_WIDTH-1:0]   rf_rdata1,
  input  logic [DATA_WIDTH-1:0]   rf_rdata2,
  output logic                    rf_we,
  output logic [BUS_WIDTH-1:0]    rf_waddr,
  output logic [DATA_WIDTH-1:0]   rf_wdata,
  output logic                    alu_en,
  output logic [OPCODE_WIDTH-1:0] alu_opcode,
  output logic [BUS_WIDTH-1:0]    alu_addr1,
  output logic [BUS_WIDTH-1:0]    alu_addr2,
  output logic [DATA_WIDTH-1:0]   alu_value1,
  output logic [DATA_WIDTH-1:0]   alu_value2,
  input  logic [DATA_WIDTH-1:0]   alu_result,
  input  logic                    alu_err,
  input  logic                    alu_finish,
  output logic                    halted,
  output logic                    err_flag,
  output logic [PC_WIDTH-1:0]     pc
);

  state_t                  r_state;
  logic [PC_WIDTH-1:0]     r_pc;
  logic [INSTR_WIDTH-1:0]  r_ir;
  logic [DATA_WIDTH-1:0]   r_value1;
  logic [DATA_WIDTH-1:0]   r_value2;
  logic                    r_imemReq;
  logic                    r_aluEn;
  logic                    r_rfWe;
  logic                    r_halted;
  logic                    r_err;

  logic [OPCODE_WIDTH-1:0] w_opcode;
  logic [BUS_WIDTH-1:0]    w_addr1;
  logic [BUS_WIDTH-1:0]    w_addr2;
  logic                    w_finish;

  assign w_opcode = r_ir[OPCODE_MSB:OPCODE_LSB];
  assign w_addr1  = r_ir[ADDR1_MSB:ADDR1_LSB];
  assign w_addr2  = r_ir[ADDR2_MSB:ADDR2_LSB];
  // Halt on the finish opcode even if the ALU does not flag it itself
  assign w_finish = alu_finish || (w_opcode == FINISH_OPCODE);

  // Single-cycle strobes default low and are re-armed only on state entry
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= SIDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_value1  <= '0;
      r_value2  <= '0;
      r_imemReq <= 1'b0;
      r_aluEn   <= 1'b0;
      r_rfWe    <= 1'b0;
      r_halted  <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_imemReq <= 1'b0;
      r_aluEn   <= 1'b0;
      r_rfWe    <= 1'b0;
      case (r_state)
        SIDLE: begin
          if (start) begin
            r_pc      <= '0;
            r_imemReq <= 1'b1;
            r_state   <= SFETCH;
          end
        end
        SFETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_data;
            r_state <= SREAD;
          end else begin
            r_imemReq <= 1'b1;
          end
        end
        SREAD: begin
          r_value1 <= rf_rdata1;
          r_value2 <= rf_rdata2;
          r_aluEn  <= 1'b1;
          r_state  <= SCALC;
        end
        SCALC: begin
          if (w_finish) begin
            r_halted <= 1'b1;
            r_state  <= SHALT;
          end else if (alu_err) begin
            r_halted <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= SHALT;
          end else begin
            r_rfWe  <= 1'b1;
            r_state <= SWRITE;
          end
        end
        SWRITE: begin
          r_pc      <= r_pc + PC_WIDTH'(1);
          r_imemReq <= 1'b1;
          r_state   <= SFETCH;
        end
        SHALT: begin
          if (start) begin
            r_halted  <= 1'b0;
            r_err     <= 1'b0;
            r_pc      <= '0;
            r_imemReq <= 1'b1;
            r_state   <= SFETCH;
          end
        end
        default: r_state <= SIDLE;
      endcase
    end
  end

  assign imem_req   = r_imemReq;
  assign imem_addr  = r_pc;
  assign rf_raddr1  = w_addr1;
  assign rf_raddr2  = w_addr2;
  assign rf_we      = r_rfWe;
  assign rf_waddr   = w_addr1;
  assign rf_wdata   = r_rfWe ? alu_result : '0;
  assign alu_en     = r_aluEn;
  assign alu_opcode = w_opcode;
  assign alu_addr1  = w_addr1;
  assign alu_addr2  = w_addr2;
  assign alu_value1 = r_value1;
  assign alu_value2 = r_value2;
  assign halted     = r_halted;
  assign err_flag   = r_err;
  assign pc         = r_pc;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer with behavioural instruction memory,
// register file and adder ALU (opcode[0]/[1] pick literal addr1/addr2).
module tb_cpu_sequencer;
  import cpu_sequencer_pkg::*;

  logic                    clk;
  logic                    rstn;
  logic                    start;
  logic                    imem_req;
  logic [PC_WIDTH-1:0]     imem_addr;
  logic                    imem_ack;
  logic [INSTR_WIDTH-1:0]  imem_data;
  logic [BUS_WIDTH-1:0]    rf_raddr1;
  logic [BUS_WIDTH-1:0]    rf_raddr2;
  logic [DATA_WIDTH-1:0]   rf_rdata1;
  logic [DATA_WIDTH-1:0]   rf_rdata2;
  logic                    rf_we;
  logic [BUS_WIDTH-1:0]    rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  logic                    alu_en;
  logic [OPCODE_WIDTH-1:0] alu_opcode;
  logic [BUS_WIDTH-1:0]    alu_addr1;
  logic [BUS_WIDTH-1:0]    alu_addr2;
  logic [DATA_WIDTH-1:0]   alu_value1;
  logic [DATA_WIDTH-1:0]   alu_value2;
  logic [DATA_WIDTH-1:0]   alu_result;
  logic                    alu_err;
  logic                    alu_finish;
  logic                    halted;
  logic                    err_flag;
  logic [PC_WIDTH-1:0]     pc;

  logic [INSTR_WIDTH-1:0]  imem [256];
  logic [DATA_WIDTH-1:0]   rf [16];
  int                      ackDelay;
  int                      stallCnt;
  logic [DATA_WIDTH-1:0]   aluOp1;
  logic [DATA_WIDTH-1:0]   aluOp2;
  int                      checkCount;
  int                      failCount;

  cpu_sequencer dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .rf_raddr1  (rf_raddr1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata1  (rf_rdata1),
    .rf_rdata2  (rf_rdata2),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .alu_en     (alu_en),
    .alu_opcode (alu_opcode),
    .alu_addr1  (alu_addr1),
    .alu_addr2  (alu_addr2),
    .alu_value1 (alu_value1),
    .alu_value2 (alu_value2),
    .alu_result (alu_result),
    .alu_err    (alu_err),
    .alu_finish (alu_finish),
    .halted     (halted),
    .err_flag   (err_flag),
    .pc         (pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory acks after ackDelay cycles of continuous request
  always @(posedge clk or negedge rstn) begin
    if (!rstn) stallCnt <= 0;
    else if (imem_req && !imem_ack) stallCnt <= stallCnt + 1;
    else stallCnt <= 0;
  end
  assign imem_ack  = imem_req && (stallCnt >= ackDelay);
  assign imem_data = imem[imem_addr];

  // Register file: combinational read, write on the clock edge
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      rf[1] <= 8'd5;
      rf[2] <= 8'd3;
      rf[4] <= 8'd5;
    end else if (rf_we) begin
      rf[rf_waddr] <= rf_wdata;
    end
  end
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  // Adder ALU registering its result on the alu_en edge
  assign aluOp1 = alu_opcode[0] ? {4'd0, alu_addr1} : alu_value1;
  assign aluOp2 = alu_opcode[1] ? {4'd0, alu_addr2} : alu_value2;
  assign alu_finish = alu_en && (alu_opcode == 6'h3f);
  always @(posedge clk or negedge rstn) begin
    if (!rstn) alu_result <= '0;
    else if (alu_en) alu_result <= aluOp1 + aluOp2;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One-cycle start pulse; returns at the negedge inside the first SFETCH
  task automatic applyStimulus();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    int  cyc;
    logic found;
    checkCount = 0;
    failCount  = 0;
    rstn       = 1'b0;
    start      = 1'b0;
    alu_err    = 1'b0;
    ackDelay   = 0;
    for (int i = 0; i < 256; i++) imem[i] = '0;
    imem[0] = {6'b000000, 4'd1, 4'd2};
    imem[1] = {6'b000010, 4'd4, 4'd3};
    imem[2] = {6'b000011, 4'd2, 4'd3};
    imem[3] = {6'b000000, 4'd2, 4'd1};
    imem[4] = {6'b111111, 4'd0, 4'd0};

    tick(2);
    checkOutput("rstImemReq", 32'(imem_req), 32'd0);
    checkOutput("rstPc", 32'(pc), 32'd0);
    checkOutput("rstHalted", 32'(halted), 32'd0);
    checkOutput("rstErr", 32'(err_flag), 32'd0);
    checkOutput("rstRfWe", 32'(rf_we), 32'd0);
    checkOutput("rstAluEn", 32'(alu_en), 32'd0);
    checkOutput("rstWdata", 32'(rf_wdata), 32'd0);
    rstn = 1'b1;
    tick(1);
    checkOutput("idleNoReq", 32'(imem_req), 32'd0);

    // pc0: r1 = r1 + r2 = 5 + 3
    applyStimulus();
    checkOutput("f0Req", 32'(imem_req), 32'd1);
    checkOutput("f0Addr", 32'(imem_addr), 32'd0);
    tick(1);
    checkOutput("r0Raddr1", 32'(rf_raddr1), 32'd1);
    checkOutput("r0Raddr2", 32'(rf_raddr2), 32'd2);
    checkOutput("r0ReqLow", 32'(imem_req), 32'd0);
    tick(1);
    checkOutput("c0AluEn", 32'(alu_en), 32'd1);
    checkOutput("c0Val1", 32'(alu_value1), 32'd5);
    checkOutput("c0Val2", 32'(alu_value2), 32'd3);
    tick(1);
    checkOutput("w0We", 32'(rf_we), 32'd1);
    checkOutput("w0Waddr", 32'(rf_waddr), 32'd1);
    checkOutput("w0Wdata", 32'(rf_wdata), 32'd8);
    checkOutput("w0AluEnLow", 32'(alu_en), 32'd0);
    tick(1);
    checkOutput("f1Pc", 32'(pc), 32'd1);
    checkOutput("f1WePulse", 32'(rf_we), 32'd0);

    // pc1: r4 = r4 + literal 3
    tick(3);
    checkOutput("w1Waddr", 32'(rf_waddr), 32'd4);
    checkOutput("w1Wdata", 32'(rf_wdata), 32'd8);

    // pc2: r2 = literal 2 + literal 3
    tick(1);
    tick(3);
    checkOutput("w2Waddr", 32'(rf_waddr), 32'd2);
    checkOutput("w2Wdata", 32'(rf_wdata), 32'd5);
    ackDelay = 3;

    // pc3 with a 3-cycle fetch stall: r2 = r2 + r1 = 5 + 8
    tick(1);
    checkOutput("s3Req", 32'(imem_req), 32'd1);
    checkOutput("s3Addr", 32'(imem_addr), 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("stallReq", 32'(imem_req), 32'd1);
      checkOutput("stallAddr", 32'(imem_addr), 32'd3);
      checkOutput("stallNoWe", 32'(rf_we), 32'd0);
    end
    ackDelay = 0;
    tick(1);
    checkOutput("r3ReqLow", 32'(imem_req), 32'd0);
    checkOutput("r3NoWe", 32'(rf_we), 32'd0);
    tick(2);
    checkOutput("w3We", 32'(rf_we), 32'd1);
    checkOutput("w3Waddr", 32'(rf_waddr), 32'd2);
    checkOutput("w3Wdata", 32'(rf_wdata), 32'd13);

    // pc4: finish opcode
    tick(4);
    checkOutput("haltHalted", 32'(halted), 32'd1);
    checkOutput("haltPc", 32'(pc), 32'd4);
    checkOutput("haltNoWe", 32'(rf_we), 32'd0);
    checkOutput("haltNoErr", 32'(err_flag), 32'd0);
    tick(1);
    checkOutput("haltHold", 32'(halted), 32'd1);
    checkOutput("haltPcHold", 32'(pc), 32'd4);

    // Restart, then force an ALU error on pc0
    applyStimulus();
    checkOutput("rsPc", 32'(pc), 32'd0);
    checkOutput("rsHalted", 32'(halted), 32'd0);
    checkOutput("rsReq", 32'(imem_req), 32'd1);
    tick(2);
    checkOutput("eAluEn", 32'(alu_en), 32'd1);
    checkOutput("eVal1", 32'(alu_value1), 32'd8);
    alu_err = 1'b1;
    tick(1);
    alu_err = 1'b0;
    checkOutput("eHalted", 32'(halted), 32'd1);
    checkOutput("eFlag", 32'(err_flag), 32'd1);
    checkOutput("eNoWe", 32'(rf_we), 32'd0);
    checkOutput("eR1Kept", 32'(rf[1]), 32'd8);
    applyStimulus();
    checkOutput("eCleared", 32'(err_flag), 32'd0);
    checkOutput("eResumeReq", 32'(imem_req), 32'd1);

    // Async reset in SREAD drops the instruction
    tick(1);
    rstn = 1'b0;
    #1;
    checkOutput("arReq", 32'(imem_req), 32'd0);
    checkOutput("arAluEn", 32'(alu_en), 32'd0);
    checkOutput("arRfWe", 32'(rf_we), 32'd0);
    checkOutput("arRaddr1", 32'(rf_raddr1), 32'd0);
    checkOutput("arVal1", 32'(alu_value1), 32'd0);
    checkOutput("arPc", 32'(pc), 32'd0);
    tick(1);
    rstn = 1'b1;
    tick(3);
    checkOutput("arIdleReq", 32'(imem_req), 32'd0);
    checkOutput("arIdleWe", 32'(rf_we), 32'd0);
    checkOutput("arIdleAluEn", 32'(alu_en), 32'd0);

    // pc wrap: fill memory with r15 = 15 + 0 and run past address 255
    for (int i = 0; i < 256; i++) imem[i] = {6'b000011, 4'd15, 4'd0};
    applyStimulus();
    found = 1'b0;
    for (cyc = 0; cyc < 1500 && !found; cyc++) begin
      tick(1);
      if (pc == 8'd255 && rf_we) found = 1'b1;
    end
    checkOutput("wrapReached", 32'(found), 32'd1);
    checkOutput("wrapWaddr", 32'(rf_waddr), 32'd15);
    checkOutput("wrapWdata", 32'(rf_wdata), 32'd15);
    tick(1);
    checkOutput("wrapPc", 32'(pc), 32'd0);
    checkOutput("wrapReq", 32'(imem_req), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
